// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game-state core.
// The ball speed-up option is selected with the BALL_SPEEDUP_EN macro in pong_game_state.
package pong_pkg;

  // Default playfield and object geometry (pixels)
  localparam int PONG_SCREEN_W     = 640;
  localparam int PONG_SCREEN_H     = 480;
  localparam int PONG_BALL_SIZE    = 8;
  localparam int PONG_PADDLE_X     = 16;
  localparam int PONG_PADDLE_W     = 8;
  localparam int PONG_PADDLE_H     = 64;
  localparam int PONG_PADDLE_SPEED = 4;
  localparam int PONG_BALL_VX      = 2;
  localparam int PONG_BALL_VY      = 2;

  // Upper bound on horizontal speed when speed-up is enabled
  localparam int PONG_VEL_MAX      = 7;

  // Width of the coordinate outputs and of the wrap-free arithmetic
  localparam int POS_W   = 10;
  localparam int ARITH_W = 11;

  // Signed per-frame velocity
  typedef logic signed [POS_W-1:0] vel_t;

  // Serve: ball glued to the paddle; play: ball in flight
  typedef enum logic {
    SERVE = 1'b0,
    PLAY  = 1'b1
  } game_state_t;

  // Magnitude of a velocity (never called with the most negative value)
  function automatic vel_t vel_abs(input vel_t v);
    return v[POS_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// Paddle vertical position: joystick-driven, saturating at the top and
// bottom of the screen, advancing only on frame-update strobes.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H     = PONG_SCREEN_H,
  parameter int PADDLE_H     = PONG_PADDLE_H,
  parameter int PADDLE_SPEED = PONG_PADDLE_SPEED
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_update,
  input  logic             i_up,
  input  logic             i_down,
  output logic [POS_W-1:0] o_paddle_y,
  output logic [POS_W-1:0] o_paddle_y_next
);

  localparam logic [ARITH_W-1:0] L_Y_MAX   = ARITH_W'(SCREEN_H - PADDLE_H);
  localparam logic [ARITH_W-1:0] L_Y_RESET = ARITH_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [ARITH_W-1:0] L_STEP    = ARITH_W'(PADDLE_SPEED);

  logic [POS_W-1:0]   r_paddle_y;
  logic [POS_W-1:0]   w_paddle_y_next;
  logic [ARITH_W-1:0] w_y_ext;

  // Candidate position for this frame; opposing inputs cancel out
  always_comb begin
    w_y_ext         = {1'b0, r_paddle_y};
    w_paddle_y_next = r_paddle_y;
    if (i_up && !i_down) begin
      if (w_y_ext < L_STEP) w_paddle_y_next = '0;
      else                  w_paddle_y_next = POS_W'(w_y_ext - L_STEP);
    end else if (i_down && !i_up) begin
      if ((w_y_ext + L_STEP) >= L_Y_MAX) w_paddle_y_next = POS_W'(L_Y_MAX);
      else                               w_paddle_y_next = POS_W'(w_y_ext + L_STEP);
    end
  end

  // Paddle register: centred on reset, moves once per frame
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_paddle_y <= POS_W'(L_Y_RESET);
    end else if (i_update) begin
      r_paddle_y <= w_paddle_y_next;
    end
  end

  assign o_paddle_y      = r_paddle_y;
  assign o_paddle_y_next = w_paddle_y_next;

endmodule

// File: rtl/pong_game_state.sv
// Pong game-state core: ball position/velocity, paddle, serve/play state.
// Optional feature macro: BALL_SPEEDUP_EN -- each paddle return adds one
// pixel/frame of horizontal speed (capped); a miss restores serve speed.
module pong_game_state
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = PONG_SCREEN_W,
  parameter int SCREEN_H     = PONG_SCREEN_H,
  parameter int BALL_SIZE    = PONG_BALL_SIZE,
  parameter int PADDLE_X     = PONG_PADDLE_X,
  parameter int PADDLE_W     = PONG_PADDLE_W,
  parameter int PADDLE_H     = PONG_PADDLE_H,
  parameter int PADDLE_SPEED = PONG_PADDLE_SPEED,
  parameter int BALL_VX      = PONG_BALL_VX,
  parameter int BALL_VY      = PONG_BALL_VY
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             update_screen,
  input  logic             joystick_up,
  input  logic             joystick_down,
  input  logic             arcade_button_pressed,
  output logic [POS_W-1:0] ball_top,
  output logic [POS_W-1:0] ball_left,
  output logic [POS_W-1:0] paddleX,
  output logic [POS_W-1:0] paddleY
);

  localparam logic [ARITH_W-1:0] L_SCREEN_W    = ARITH_W'(SCREEN_W);
  localparam logic [ARITH_W-1:0] L_SCREEN_H    = ARITH_W'(SCREEN_H);
  localparam logic [ARITH_W-1:0] L_BALL_SIZE   = ARITH_W'(BALL_SIZE);
  localparam logic [ARITH_W-1:0] L_PADDLE_H    = ARITH_W'(PADDLE_H);
  localparam logic [ARITH_W-1:0] L_PADDLE_EDGE = ARITH_W'(PADDLE_X + PADDLE_W);
  localparam logic [ARITH_W-1:0] L_GLUE_OFS    = ARITH_W'((PADDLE_H - BALL_SIZE) / 2);
  localparam logic [ARITH_W-1:0] L_TOP_RESET   =
    ARITH_W'((SCREEN_H - PADDLE_H) / 2 + (PADDLE_H - BALL_SIZE) / 2);
`ifdef BALL_SPEEDUP_EN
  localparam logic [ARITH_W-1:0] L_VEL_MAX     = ARITH_W'(PONG_VEL_MAX);
`endif
  localparam vel_t L_SERVE_VX = POS_W'(BALL_VX);
  localparam vel_t L_SERVE_VY = POS_W'(BALL_VY);

  game_state_t      r_state;
  logic [POS_W-1:0] r_ball_left;
  logic [POS_W-1:0] r_ball_top;
  vel_t             r_vel_x;
  vel_t             r_vel_y;

  logic [POS_W-1:0]   w_paddle_y;
  logic [POS_W-1:0]   w_paddle_y_next;
  logic [ARITH_W-1:0] w_left_ext, w_top_ext, w_py_ext, w_ball_right;
  logic [ARITH_W-1:0] w_vx_mag, w_vy_mag;
  logic               w_vx_neg, w_vx_pos, w_vy_neg, w_vy_pos;
  logic               w_hit_right, w_hit_paddle, w_miss, w_hit_top, w_hit_bottom;
  logic [POS_W-1:0]   w_left_next, w_top_next, w_glue_top;
  vel_t               w_vx_next, w_vy_next;

  pong_paddle_ctrl #(
    .SCREEN_H     (SCREEN_H),
    .PADDLE_H     (PADDLE_H),
    .PADDLE_SPEED (PADDLE_SPEED)
  ) u_paddle (
    .i_clock         (clock),
    .i_reset_n       (reset),
    .i_update        (update_screen),
    .i_up            (joystick_up),
    .i_down          (joystick_down),
    .o_paddle_y      (w_paddle_y),
    .o_paddle_y_next (w_paddle_y_next)
  );

  // Collision detection and candidate ball motion from pre-update values
  always_comb begin
    w_left_ext   = {1'b0, r_ball_left};
    w_top_ext    = {1'b0, r_ball_top};
    w_py_ext     = {1'b0, w_paddle_y};
    w_ball_right = w_left_ext + L_BALL_SIZE;
    w_vx_mag     = {1'b0, vel_abs(r_vel_x)};
    w_vy_mag     = {1'b0, vel_abs(r_vel_y)};
    w_vx_neg     = r_vel_x[POS_W-1];
    w_vx_pos     = !r_vel_x[POS_W-1] && (r_vel_x != '0);
    w_vy_neg     = r_vel_y[POS_W-1];
    w_vy_pos     = !r_vel_y[POS_W-1] && (r_vel_y != '0);

    w_hit_right  = w_vx_pos && ((w_ball_right + w_vx_mag) >= L_SCREEN_W);
    // "left + vx <= edge" is rewritten as "left <= edge + |vx|" to stay unsigned
    w_hit_paddle = w_vx_neg
                && (w_left_ext >= L_PADDLE_EDGE)
                && (w_left_ext <= (L_PADDLE_EDGE + w_vx_mag))
                && ((w_top_ext + L_BALL_SIZE) > w_py_ext)
                && (w_top_ext < (w_py_ext + L_PADDLE_H));
    w_miss       = w_vx_neg && !w_hit_paddle && (w_left_ext < w_vx_mag);
    w_hit_top    = w_vy_neg && (w_top_ext < w_vy_mag);
    w_hit_bottom = w_vy_pos && ((w_top_ext + L_BALL_SIZE + w_vy_mag) >= L_SCREEN_H);

    w_left_next = r_ball_left;
    w_vx_next   = r_vel_x;
    if (w_hit_right) begin
      w_left_next = POS_W'(L_SCREEN_W - L_BALL_SIZE);
      w_vx_next   = -r_vel_x;
    end else if (w_hit_paddle) begin
      w_left_next = POS_W'(L_PADDLE_EDGE);
`ifdef BALL_SPEEDUP_EN
      // Velocity was negative, so the returned ball always travels right
      if (w_vx_mag >= L_VEL_MAX) w_vx_next = $signed(POS_W'(L_VEL_MAX));
      else                       w_vx_next = $signed(POS_W'(w_vx_mag + 11'd1));
`else
      w_vx_next   = -r_vel_x;
`endif
    end else if (w_vx_neg) begin
      // On a miss this underflows, but the miss path discards it
      w_left_next = POS_W'(w_left_ext - w_vx_mag);
    end else begin
      w_left_next = POS_W'(w_left_ext + w_vx_mag);
    end

    w_top_next = r_ball_top;
    w_vy_next  = r_vel_y;
    if (w_hit_top) begin
      w_top_next = '0;
      w_vy_next  = -r_vel_y;
    end else if (w_hit_bottom) begin
      w_top_next = POS_W'(L_SCREEN_H - L_BALL_SIZE);
      w_vy_next  = -r_vel_y;
    end else if (w_vy_neg) begin
      w_top_next = POS_W'(w_top_ext - w_vy_mag);
    end else begin
      w_top_next = POS_W'(w_top_ext + w_vy_mag);
    end

    // While served, the ball sits centred on the paddle's new position
    w_glue_top = POS_W'({1'b0, w_paddle_y_next} + L_GLUE_OFS);
  end

  // Serve/play state machine and ball registers, advanced once per frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= SERVE;
      r_ball_left <= POS_W'(L_PADDLE_EDGE);
      r_ball_top  <= POS_W'(L_TOP_RESET);
      r_vel_x     <= L_SERVE_VX;
      r_vel_y     <= L_SERVE_VY;
    end else if (update_screen) begin
      case (r_state)
        SERVE: begin
          r_ball_left <= POS_W'(L_PADDLE_EDGE);
          r_ball_top  <= w_glue_top;
          if (arcade_button_pressed) r_state <= PLAY;
        end
        PLAY: begin
          if (w_miss) begin
            r_state     <= SERVE;
            r_ball_left <= POS_W'(L_PADDLE_EDGE);
            r_ball_top  <= w_glue_top;
            r_vel_x     <= L_SERVE_VX;
            r_vel_y     <= L_SERVE_VY;
          end else begin
            r_ball_left <= w_left_next;
            r_ball_top  <= w_top_next;
            r_vel_x     <= w_vx_next;
            r_vel_y     <= w_vy_next;
          end
        end
        default: r_state <= SERVE;
      endcase
    end
  end

  assign ball_left = r_ball_left;
  assign ball_top  = r_ball_top;
  assign paddleX   = POS_W'(PADDLE_X);
  assign paddleY   = w_paddle_y;

endmodule

// File: tb/tb_pong_game_state.sv
// Directed bench for pong_game_state: reset values, paddle saturation,
// serve, wall bounces, miss/re-serve, paddle return and async reset.
module tb_pong_game_state;

  logic       clock;
  logic       reset;
  logic       update_screen;
  logic       joystick_up;
  logic       joystick_down;
  logic       arcade_button_pressed;
  logic [9:0] ball_top;
  logic [9:0] ball_left;
  logic [9:0] paddleX;
  logic [9:0] paddleY;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pong_game_state dut (
    .clock                 (clock),
    .reset                 (reset),
    .update_screen         (update_screen),
    .joystick_up           (joystick_up),
    .joystick_down         (joystick_down),
    .arcade_button_pressed (arcade_button_pressed),
    .ball_top              (ball_top),
    .ball_left             (ball_left),
    .paddleX               (paddleX),
    .paddleY               (paddleY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic check_all(input string tag, input int left, input int top, input int py);
    check({tag, ".left"},   ball_left, 10'(left));
    check({tag, ".top"},    ball_top,  10'(top));
    check({tag, ".paddle"}, paddleY,   10'(py));
    $display("step %-14s left=%0d top=%0d paddleY=%0d", tag, ball_left, ball_top, paddleY);
  endtask

  // Advance n clock edges, then sample 1 time unit after the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset                 = 1'b0;
    update_screen         = 1'b0;
    joystick_up           = 1'b0;
    joystick_down         = 1'b0;
    arcade_button_pressed = 1'b0;

    // Held in reset
    #12;
    check_all("reset", 24, 236, 208);
    check("reset.paddleX", paddleX, 10'd16);

    @(negedge clock);
    reset         = 1'b1;
    update_screen = 1'b1;
    step(5);
    check_all("idle_serve", 24, 236, 208);

    // No update strobe: joystick must be ignored
    update_screen = 1'b0;
    joystick_up   = 1'b1;
    step(3);
    check_all("no_update", 24, 236, 208);

    // Up to the top, saturating at 0
    update_screen = 1'b1;
    step(1);
    check_all("up_1", 24, 232, 204);
    step(59);
    check_all("up_60", 24, 28, 0);

    // Down to the bottom, saturating at 416
    joystick_up   = 1'b0;
    joystick_down = 1'b1;
    step(110);
    check_all("down_110", 24, 444, 416);

    // Both pressed: hold
    joystick_up = 1'b1;
    step(3);
    check_all("both", 24, 444, 416);

    // Back to the centre
    joystick_down = 1'b0;
    step(52);
    check_all("recentre", 24, 236, 208);
    joystick_up = 1'b0;

    // Serve: launch update keeps the ball glued, motion follows
    arcade_button_pressed = 1'b1;
    step(1);
    arcade_button_pressed = 1'b0;
    check_all("launch", 24, 236, 208);
    step(1);
    check_all("play_1", 26, 238, 208);
    step(1);
    check_all("play_2", 28, 240, 208);

    // Bottom wall
    step(115);
    check_all("play_117", 258, 470, 208);
    step(1);
    check_all("bottom_118", 260, 472, 208);
    step(1);
    check_all("after_bot", 262, 470, 208);

    // Right wall
    step(184);
    check_all("play_303", 630, 102, 208);
    step(1);
    check_all("right_304", 632, 100, 208);
    step(1);
    check_all("after_right", 630, 98, 208);

    // Paddle to the top while the ball travels back; top wall on the way
    joystick_up = 1'b1;
    step(49);
    check_all("play_354", 532, 0, 12);
    step(1);
    check_all("top_355", 530, 0, 8);
    step(1);
    check_all("after_top", 528, 2, 4);
    step(9);
    check_all("play_365", 510, 20, 0);
    joystick_up = 1'b0;

    // Second bottom bounce, then the ball passes the paddle rows unhit
    step(226);
    check_all("bottom_591", 58, 472, 0);
    step(16);
    check_all("play_607", 26, 440, 0);
    step(1);
    check_all("no_hit_608", 24, 438, 0);
    step(1);
    check_all("past_pad", 22, 436, 0);
    step(11);
    check_all("play_620", 0, 414, 0);

    // Miss: back to serve, glued to the paddle at row 0
    step(1);
    check_all("miss", 24, 28, 0);
    step(1);
    check_all("reserved", 24, 28, 0);

    // Second rally with serve velocity restored; paddle moved down to 272
    arcade_button_pressed = 1'b1;
    step(1);
    arcade_button_pressed = 1'b0;
    check_all("launch2", 24, 28, 0);
    joystick_down = 1'b1;
    step(1);
    check_all("r2_1", 26, 30, 4);
    step(67);
    check_all("r2_68", 160, 164, 272);
    joystick_down = 1'b0;
    step(539);
    check_all("r2_607", 26, 296, 272);

    // Paddle return: ball clamped to the paddle face and sent right again
    step(1);
    check_all("pad_hit", 24, 298, 272);
    step(1);
    check_all("after_hit", 26, 300, 272);

    // Asynchronous reset mid-play, no clock edge and no update strobe
    update_screen = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 24, 236, 208);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pong_game_state.md
Name: pong_game_state

Overview:
- Game-state core of the single-player pong: owns the ball position, ball velocity, paddle position and the serve/play state.
- Advances one frame per `update_screen` pulse from the video timing block.
- Drives the object coordinates consumed by the pixel renderer.
- Player inputs: joystick up/down and one arcade button, all already synchronised and debounced upstream.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 8, ball edge length (square)
- PADDLE_X, 16, fixed left column of the paddle
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- PADDLE_SPEED, 4, paddle pixels moved per frame
- BALL_VX, 2, serve horizontal speed magnitude
- BALL_VY, 2, serve vertical speed magnitude

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- update_screen  in  1  frame-advance strobe; state changes only on cycles where it is 1
- joystick_up  in  1  move paddle toward row 0
- joystick_down  in  1  move paddle toward SCREEN_H
- arcade_button_pressed  in  1  serve request (level)
- ball_top  out  10  ball top row, unsigned
- ball_left  out  10  ball left column, unsigned
- paddleX  out  10  paddle left column (constant PADDLE_X)
- paddleY  out  10  paddle top row, unsigned

Behaviour:
- Reset (reset==0, async) values:
  - paddleY = (SCREEN_H-PADDLE_H)/2 = 208; paddleX = 16
  - state = SERVE
  - ball_left = PADDLE_X+PADDLE_W = 24; ball_top = paddleY + (PADDLE_H-BALL_SIZE)/2 = 236
  - vel_x = +BALL_VX; vel_y = +BALL_VY
- Internal signals:
  - vel_x, vel_y: signed 10-bit.
  - ball_right = ball_left + BALL_SIZE (combinational, unsigned).
- update_screen==0: all registers hold.
- Paddle, each update:
  - up-only: paddleY -= PADDLE_SPEED, saturating at 0.
  - down-only: paddleY += PADDLE_SPEED, saturating at SCREEN_H-PADDLE_H = 416.
  - both or neither pressed: hold.
- SERVE state:
  - Ball is glued to the paddle: ball_left = 24, ball_top = new paddleY + 28.
  - If arcade_button_pressed is high on an update, go to PLAY; movement starts on the following update.
- PLAY state, each update, horizontal and vertical evaluated independently using current (pre-update) values:
  - Right wall: vel_x>0 and ball_right + vel_x >= SCREEN_W → ball_left = SCREEN_W-BALL_SIZE, vel_x = -vel_x.
  - Paddle hit: all of the following → ball_left = PADDLE_X+PADDLE_W, vel_x = -vel_x:
    - vel_x<0
    - ball_left >= PADDLE_X+PADDLE_W
    - ball_left + vel_x <= PADDLE_X+PADDLE_W
    - ball_top+BALL_SIZE > paddleY and ball_top < paddleY+PADDLE_H (pre-update paddleY)
  - Miss: vel_x<0, no paddle hit and ball_left < |vel_x| → state = SERVE, vel_x = +BALL_VX, vel_y = +BALL_VY; ball is re-glued on the same update.
  - Otherwise: ball_left += vel_x.
  - Top wall: vel_y<0 and ball_top < |vel_y| → ball_top = 0, vel_y negated.
  - Bottom wall: vel_y>0 and ball_top + BALL_SIZE + vel_y >= SCREEN_H → ball_top = SCREEN_H-BALL_SIZE, vel_y negated.
  - Otherwise: ball_top += vel_y.
- Corner case: simultaneous horizontal and vertical bounce applies both.
- Arithmetic: all position arithmetic is 11-bit to avoid wrap; outputs never leave [0, SCREEN-size].

Optional Feature:
- Macro BALL_SPEEDUP_EN.
  - Defined: each paddle hit also increases |vel_x| by 1, capped at 7 (sign preserved after negation). A miss restores BALL_VX.
  - Undefined: |vel_x| stays BALL_VX forever.

Decomposition:
- Package pong_pkg holds:
  - screen/ball/paddle constants
  - typedef enum logic {SERVE, PLAY} game_state_t
  - the signed velocity typedef
- Sub-module pong_paddle_ctrl: joystick → saturating paddleY register.

Test Plan:
- Reset low, then high, no inputs, update_screen=1 → ball_left=24, ball_top=236, paddleY=208, paddleX=16, state SERVE indefinitely.
- joystick_up held 60 updates → paddleY decreases by 4 per update, sticks at 0; ball_top tracks paddleY+28 (28 at end).
- Button pulse on one update at reset position → next updates ball_left 26, 28, …; ball_top 238, 240, ….
- Continue play:
  - Bottom bounce: ball_top reaches 470 at update 117 after launch; update 118 → ball_top=472, vel_y=-2.
  - Right bounce: ball_left reaches 630 at update 303; update 304 → ball_left=632, vel_x=-2.
- Return with paddle moved to 0 (ball not overlapping paddle rows) → ball_left falls below 2, state returns to SERVE, ball re-glued at paddle, vel reset to +2/+2.
- reset asserted mid-play with update_screen=0 → outputs return to reset values immediately, without waiting for a clock edge.
